id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register and EX operand network directly upstream of the ALU.
//  - Latches decoded instructions and applies MEM/WB bypass forwarding.
//  - Selects the ALU a/b operands.
//  - Inserts a one-cycle bubble on a load-use hazard.
//  - Valid/ready handshake on both sides; flush from branch resolution.
// PARAMETERS
//  XLEN        32  datapath width
//  RA_W        5   register address width
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous reset, active high
//  flush          in   1       discard EX contents and the offered ID instruction
//  id_valid       in   1       decode offers an instruction
//  id_ready       out  1       stage accepts the offered instruction this cycle
//  id_pc          in   XLEN    instruction PC
//  id_rs1_data    in   XLEN    regfile read port 1
//  id_rs2_data    in   XLEN    regfile read port 2
//  id_imm         in   XLEN    sign-extended immediate
//  id_rs1/id_rs2  in   RA_W    source register indices
//  id_rd          in   RA_W    destination register index
//  id_a_sel       in   2       ALU a source: 0=rs1, 1=pc, 2=zero, 3=zero
//  id_b_sel       in   1       ALU b source: 0=rs2, 1=imm
//  id_alu_ctrl    in   aluCtrl_e  ALU operation
//  id_reg_write   in   1       instruction writes rd
//  id_mem_read    in   1       instruction is a load
//  id_mem_write   in   1       instruction is a store
//  mem_rd, mem_reg_write, mem_fwd_data    in  RA_W/1/XLEN  EX/MEM bypass source
//  wb_rd,  wb_reg_write,  wb_fwd_data     in  RA_W/1/XLEN  MEM/WB bypass source
//  ex_valid       out  1       EX holds a valid instruction
//  ex_ready       in   1       downstream accepts the EX instruction
//  alu_a, alu_b   out  XLEN    ALU operands
//  alu_ctrl       out  aluCtrl_e  ALU operation
//  ex_store_data  out  XLEN    forwarded rs2 value for stores
//  ex_pc          out  XLEN    EX instruction PC
//  ex_rd          out  RA_W    EX destination index
//  ex_reg_write, ex_mem_read, ex_mem_write   out  1  registered control
// BEHAVIOUR
//  - Reset: ex_valid=0, all control and data registers 0, alu_ctrl=ALU_ADD.
//  - advance = !ex_valid | ex_ready.
//  - hazard  = ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
//    Comparisons are unconditional; false hazards on unused sources are accepted.
//  - id_ready = advance & !hazard & !flush.
//  - Clock edge, in priority order:
//    - flush: ex_valid<=0; ID instruction dropped.
//    - else advance & id_valid & !hazard: load all registers, ex_valid<=1.
//    - else advance: ex_valid<=0 (bubble; control registers cleared).
//    - else hold everything.
//  - Forwarding (combinational, per source rs1/rs2 of the EX instruction):
//    - MEM if mem_reg_write & mem_rd!=0 & mem_rd==rs.
//    - else WB if wb_reg_write & wb_rd!=0 & wb_rd==rs.
//    - else the registered regfile value.
//    - MEM has priority over WB. Register x0 is never forwarded.
//  - alu_a = rs1 forwarded value, ex_pc, or 0 per a_sel. alu_b = rs2 forwarded value or imm per b_sel.
//  - ex_store_data is always the forwarded rs2 value.
//  - Latency: one cycle from ID acceptance to the operands presented to the ALU.
//  - Load-use: exactly one bubble; the dependent instruction then forwards from WB.
//  - Drivers must hold the MEM/WB bypass inputs stable while ex_valid & !ex_ready (global stall).
//  - Reset asserted mid-operation clears ex_valid immediately (asynchronous); no partial state survives.
// CONFIGURATION
//  - Macro IDEX_PERF_CNT_EN defined:
//    - Adds output bubble_cnt [31:0].
//    - Counts cycles where the bubble branch is taken with id_valid=1 (hazard or stall-induced bubble).
//    - Reset 0; wraps 0xFFFFFFFF -> 0; not affected by flush.
//  - Macro not defined: port and counter are absent; all other behaviour is identical.
// TESTING
//  - Reset with id_valid=1: ex_valid=0 and alu_ctrl=ALU_ADD during reset.
//    First rising edge after release captures the instruction.
//  - ADD x3,x1,x2 with x1=5, x2=7 from the regfile, no bypass hits -> next cycle alu_a=5, alu_b=7, ex_valid=1.
//  - Bypass priority: mem_rd=1 with mem_fwd_data=0x10, and wb_rd=1 with wb_fwd_data=0x20 -> alu_a=0x10.
//    Same case with rd=0 on both bypasses -> alu_a equals the regfile value.
//  - LW x4 in EX, ID offers ADD x5,x4,x4 -> id_ready=0 for one cycle, then one bubble (ex_valid=0).
//    ADD then enters with wb_rd=4 forwarding -> alu_a=alu_b=wb_fwd_data.
//    With the macro defined, bubble_cnt increments by 1.
//  - ex_ready=0 for 3 cycles -> EX outputs unchanged, id_ready=0.
//    flush while stalled -> ex_valid=0 on the next edge.
//  - I-type with b_sel=1, imm=0xFFFFF800, and a_sel=1, pc=0x100 -> alu_a=0x100, alu_b=0xFFFFF800.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB bypass forwarding, ALU operand select and load-use bubble.
// Optional bubble counter enabled by defining IDEX_PERF_CNT_EN.
package id_ex_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_ctrl_e;
endpackage

module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic [1:0]      id_a_sel,
    input  logic            id_b_sel,
    input  alu_ctrl_e       id_alu_ctrl,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_fwd_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output alu_ctrl_e       alu_ctrl,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [31:0]     bubble_cnt
`endif
);

    localparam int unsigned CNT_W = 32;

    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
    logic [RA_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [1:0]      a_sel_q, a_sel_d;
    logic            b_sel_q, b_sel_d;
    alu_ctrl_e       alu_ctrl_q, alu_ctrl_d;
    logic            reg_write_q, reg_write_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    logic            advance_c, hazard_c, load_c, bubble_c;
    logic [XLEN-1:0] rs1_fwd_c, rs2_fwd_c;

    // Handshake and load-use detection against the instruction currently in EX
    always_comb begin
        advance_c = !ex_valid_q || ex_ready;
        hazard_c  = ex_valid_q && mem_read_q && (rd_q != '0) &&
                    ((rd_q == id_rs1) || (rd_q == id_rs2));
        id_ready  = advance_c && !hazard_c && !flush;
        load_c    = !flush && advance_c && id_valid && !hazard_c;
        bubble_c  = !flush && advance_c && !load_c;
    end

    always_comb begin
        ex_valid_d   = ex_valid_q;
        pc_d         = pc_q;
        rs1_data_d   = rs1_data_q;
        rs2_data_d   = rs2_data_q;
        imm_d        = imm_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        a_sel_d      = a_sel_q;
        b_sel_d      = b_sel_q;
        alu_ctrl_d   = alu_ctrl_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        bubble_cnt_d = bubble_cnt_q;
        if (flush || bubble_c) begin
            ex_valid_d  = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end else if (load_c) begin
            ex_valid_d  = 1'b1;
            pc_d        = id_pc;
            rs1_data_d  = id_rs1_data;
            rs2_data_d  = id_rs2_data;
            imm_d       = id_imm;
            rs1_d       = id_rs1;
            rs2_d       = id_rs2;
            rd_d        = id_rd;
            a_sel_d     = id_a_sel;
            b_sel_d     = id_b_sel;
            alu_ctrl_d  = id_alu_ctrl;
            reg_write_d = id_reg_write;
            mem_read_d  = id_mem_read;
            mem_write_d = id_mem_write;
        end
`ifdef IDEX_PERF_CNT_EN
        if (bubble_c && id_valid) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            pc_q         <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            a_sel_q      <= '0;
            b_sel_q      <= 1'b0;
            alu_ctrl_q   <= ALU_ADD;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            pc_q         <= pc_d;
            rs1_data_q   <= rs1_data_d;
            rs2_data_q   <= rs2_data_d;
            imm_q        <= imm_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            a_sel_q      <= a_sel_d;
            b_sel_q      <= b_sel_d;
            alu_ctrl_q   <= alu_ctrl_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Bypass: MEM beats WB, x0 never forwarded
    always_comb begin
        rs1_fwd_c = rs1_data_q;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs1_q)) begin
            rs1_fwd_c = mem_fwd_data;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs1_q)) begin
            rs1_fwd_c = wb_fwd_data;
        end
        rs2_fwd_c = rs2_data_q;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs2_q)) begin
            rs2_fwd_c = mem_fwd_data;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs2_q)) begin
            rs2_fwd_c = wb_fwd_data;
        end
    end

    always_comb begin
        case (a_sel_q)
            2'd0:    alu_a = rs1_fwd_c;
            2'd1:    alu_a = pc_q;
            default: alu_a = '0;
        endcase
        alu_b         = b_sel_q ? imm_q : rs2_fwd_c;
        ex_store_data = rs2_fwd_c;
        alu_ctrl      = alu_ctrl_q;
        ex_valid      = ex_valid_q;
        ex_pc         = pc_q;
        ex_rd         = rd_q;
        ex_reg_write  = reg_write_q;
        ex_mem_read   = mem_read_q;
        ex_mem_write  = mem_write_q;
    end

`ifdef IDEX_PERF_CNT_EN
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
